id_ex_stage_reg: RTL and testbench
==================================

// Module: id_ex_stage_reg
// PURPOSE
//  ID->EX pipeline register between the decode stage and the execute stage. Captures the
//  decoded bundle (inst, op1, op2, reg_we, reg_waddr) with a valid/ready handshake on both
//  sides, and has a 1-entry skid buffer so that id_ready_o is a pure register output.
//  Supports a synchronous flush for branch/jump redirect, which turns the stage into a bubble.
// PARAMETERS
//  none; widths come from defines.v: `DATA_WIDTH=32, `RDATA_WIDTH=32, `RADDR_WIDTH=5
// PORTS
//  clk          in   1             clock, all state on posedge
//  rst_n        in   1             asynchronous, active-low reset
//  flush_i      in   1             sync flush: discard all held entries, highest priority
//  id_valid_i   in   1             decode bundle valid
//  id_ready_o   out  1             stage can accept a bundle this cycle (registered)
//  inst_i       in   DATA_WIDTH    decoded instruction word
//  op1_i        in   RDATA_WIDTH   operand 1
//  op2_i        in   RDATA_WIDTH   operand 2 / sign-extended immediate
//  reg_we_i     in   1             destination write enable
//  reg_waddr_i  in   RADDR_WIDTH   destination register index
//  ex_valid_o   out  1             bundle presented to EX is valid
//  ex_ready_i   in   1             EX consumes the bundle this cycle
//  inst_o       out  DATA_WIDTH    held instruction
//  op1_o        out  RDATA_WIDTH   held operand 1
//  op2_o        out  RDATA_WIDTH   held operand 2
//  reg_we_o     out  1             held write enable, forced 0 when ex_valid_o=0
//  reg_waddr_o  out  RADDR_WIDTH   held destination index
// BEHAVIOUR
//  - Storage: main entry (drives all *_o) plus skid entry. push = id_valid_i & id_ready_o;
//    pop = ex_valid_o & ex_ready_i.
//  - State encoding: EMPTY (no entries), ONE (main valid), TWO (main+skid valid).
//    ex_valid_o = (state!=EMPTY); id_ready_o = (state!=TWO), held as a register.
//  - EMPTY: push -> ONE, main<=in.
//  - ONE: push&pop -> ONE, main<=in. push&!pop -> TWO, skid<=in. !push&pop -> EMPTY.
//    Neither -> hold.
//  - TWO: no push is possible. pop -> ONE, main<=skid. No pop -> hold.
//  - flush_i=1: next state EMPTY regardless of push/pop that cycle. The incoming bundle is
//    dropped. id_ready_o=1 and ex_valid_o=0 on the next cycle.
//  - Latency: 1 cycle from push to ex_valid_o. Throughput: 1 bundle/cycle while ex_ready_i=1.
//  - Ordering is strictly FIFO: bundles are never dropped or duplicated except by flush.
//  - Payload regs keep stale data when their entry is invalid.
//    reg_we_o = main_we & ex_valid_o, so a bubble never writes.
//  - Reset (rst_n=0, async): state EMPTY; all payload regs 0; ex_valid_o=0,
//    reg_we_o=0, reg_waddr_o=0, op1_o=op2_o=inst_o=0; id_ready_o=1.
//    Reset mid-transfer discards all entries.
//  - Outputs are stable while ex_valid_o=1 and ex_ready_i=0 (AXI-style hold rule).
//  - id_valid_i while id_ready_o=0 is ignored; upstream must hold the bundle.
// TESTING
//  1 reset: rst_n=0 async mid-cycle -> immediately ex_valid_o=0, reg_we_o=0, outputs 0,
//    id_ready_o=1.
//  2 streaming: ex_ready_i=1, push addi x5 (op1=7, op2=3, waddr=5) then 3 more back-to-back ->
//    each appears 1 cycle later in order, 4 bundles in 4 cycles, id_ready_o stays 1.
//  3 backpressure: ex_ready_i=0, push A then B -> state TWO, id_ready_o=0, outputs hold A;
//    raise ex_ready_i -> A pops, then B is presented, then id_ready_o returns to 1.
//  4 ignored push: in TWO, drive id_valid_i=1 with bundle C -> C is not captured. After drain,
//    re-present C -> it is accepted exactly once.
//  5 flush: in TWO, flush_i=1 together with id_valid_i=1 -> next cycle ex_valid_o=0,
//    reg_we_o=0, id_ready_o=1, and no A/B/new bundle ever emerges.
//  6 simultaneous push&pop in ONE with ex_ready_i=1 -> main is replaced by the new bundle
//    and the state stays ONE; a scoreboard checks FIFO order over 1000 random valid/ready cycles.

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// ID->EX pipeline register with a one-entry skid buffer so the upstream ready is a
// pure flop; a synchronous flush turns the stage into a bubble.
module id_ex_stage_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        id_valid_i,
  output logic        id_ready_o,
  input  logic [31:0] inst_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic        reg_we_i,
  input  logic [4:0]  reg_waddr_i,
  output logic        ex_valid_o,
  input  logic        ex_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] op1_o,
  output logic [31:0] op2_o,
  output logic        reg_we_o,
  output logic [4:0]  reg_waddr_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        ready_q;
  logic        push, pop;
  logic        load_main_in, load_main_skid, load_skid;

  logic [31:0] main_inst, main_op1, main_op2;
  logic        main_we;
  logic [4:0]  main_waddr;
  logic [31:0] skid_inst, skid_op1, skid_op2;
  logic        skid_we;
  logic [4:0]  skid_waddr;

  assign ex_valid_o = (state_q != EMPTY);
  assign id_ready_o = ready_q;
  assign push       = id_valid_i & ready_q;
  assign pop        = ex_valid_o & ex_ready_i;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d      = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (push && pop) begin
            load_main_in = 1'b1;
          end else if (push) begin
            state_d   = TWO;
            load_skid = 1'b1;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            state_d        = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Ready is registered from the next state so it never depends on ex_ready_i combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != TWO);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_inst  <= '0;
      main_op1   <= '0;
      main_op2   <= '0;
      main_we    <= 1'b0;
      main_waddr <= '0;
    end else if (load_main_in) begin
      main_inst  <= inst_i;
      main_op1   <= op1_i;
      main_op2   <= op2_i;
      main_we    <= reg_we_i;
      main_waddr <= reg_waddr_i;
    end else if (load_main_skid) begin
      main_inst  <= skid_inst;
      main_op1   <= skid_op1;
      main_op2   <= skid_op2;
      main_we    <= skid_we;
      main_waddr <= skid_waddr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_inst  <= '0;
      skid_op1   <= '0;
      skid_op2   <= '0;
      skid_we    <= 1'b0;
      skid_waddr <= '0;
    end else if (load_skid) begin
      skid_inst  <= inst_i;
      skid_op1   <= op1_i;
      skid_op2   <= op2_i;
      skid_we    <= reg_we_i;
      skid_waddr <= reg_waddr_i;
    end
  end

  // A bubble must never write the register file, even though main keeps stale data.
  assign reg_we_o    = main_we & ex_valid_o;
  assign inst_o      = main_inst;
  assign op1_o       = main_op1;
  assign op2_o       = main_op2;
  assign reg_waddr_o = main_waddr;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: a per-cycle vector table for directed cases,
// a queue scoreboard for random valid/ready traffic, and an async reset mid-transfer.
module tb_id_ex_stage_reg;

  logic        clk;
  logic        rst_n;
  logic        flush_i;
  logic        id_valid_i;
  logic        id_ready_o;
  logic [31:0] inst_i;
  logic [31:0] op1_i;
  logic [31:0] op2_i;
  logic        reg_we_i;
  logic [4:0]  reg_waddr_i;
  logic        ex_valid_o;
  logic        ex_ready_i;
  logic [31:0] inst_o;
  logic [31:0] op1_o;
  logic [31:0] op2_o;
  logic        reg_we_o;
  logic [4:0]  reg_waddr_o;

  int total_checks;
  int passed_checks;

  id_ex_stage_reg dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .id_valid_i  (id_valid_i),
    .id_ready_o  (id_ready_o),
    .inst_i      (inst_i),
    .op1_i       (op1_i),
    .op2_i       (op2_i),
    .reg_we_i    (reg_we_i),
    .reg_waddr_i (reg_waddr_i),
    .ex_valid_o  (ex_valid_o),
    .ex_ready_i  (ex_ready_i),
    .inst_o      (inst_o),
    .op1_o       (op1_o),
    .op2_o       (op2_o),
    .reg_we_o    (reg_we_o),
    .reg_waddr_o (reg_waddr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        we;
    logic [4:0]  waddr;
  } bundle_t;

  // Inputs for one cycle and the outputs expected right after that cycle's edge.
  typedef struct {
    logic flush;
    logic valid;
    int   tag;
    logic ready;
    logic exp_valid;
    logic exp_ready;
    int   exp_tag;
  } vec_t;

  // Tag 1 is addi x5 with op1=7, op2=3; later tags vary every field.
  function automatic bundle_t mkb(input int t);
    bundle_t b;
    b.inst  = 32'h0000_0293 | (32'(t) << 20);
    b.op1   = 32'd7 * 32'(t);
    b.op2   = 32'd3 * 32'(t);
    b.we    = ((t % 3) != 0);
    b.waddr = 5'(5 + t - 1);
    return b;
  endfunction

  function automatic vec_t mkv(input logic f, input logic v, input int t, input logic r,
                               input logic ev, input logic er, input int et);
    vec_t x;
    x.flush = f; x.valid = v; x.tag = t; x.ready = r;
    x.exp_valid = ev; x.exp_ready = er; x.exp_tag = et;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_checks++;
    if (act !== exp)
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else
      passed_checks++;
  endtask

  task automatic driveBundle(input logic f, input logic v, input int t, input logic r);
    bundle_t b;
    b           = mkb(t);
    flush_i     = f;
    id_valid_i  = v;
    ex_ready_i  = r;
    inst_i      = b.inst;
    op1_i       = b.op1;
    op2_i       = b.op2;
    reg_we_i    = b.we;
    reg_waddr_i = b.waddr;
  endtask

  task automatic applyStimulus(input vec_t v);
    driveBundle(v.flush, v.valid, v.tag, v.ready);
  endtask

  task automatic checkPayload(input string pfx, input bundle_t b);
    check({pfx, "_inst"},  inst_o, b.inst);
    check({pfx, "_op1"},   op1_o, b.op1);
    check({pfx, "_op2"},   op2_o, b.op2);
    check({pfx, "_we"},    32'(reg_we_o), 32'(b.we));
    check({pfx, "_waddr"}, 32'(reg_waddr_o), 32'(b.waddr));
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    string pfx;
    pfx = $sformatf("vec%0d", idx);
    check({pfx, "_ex_valid"}, 32'(ex_valid_o), 32'(v.exp_valid));
    check({pfx, "_id_ready"}, 32'(id_ready_o), 32'(v.exp_ready));
    if (v.exp_valid)
      checkPayload(pfx, mkb(v.exp_tag));
    else
      check({pfx, "_we_bubble"}, 32'(reg_we_o), 32'd0);
  endtask

  task automatic checkResetOutputs(input string pfx);
    check({pfx, "_ex_valid"}, 32'(ex_valid_o), 32'd0);
    check({pfx, "_we"},       32'(reg_we_o), 32'd0);
    check({pfx, "_waddr"},    32'(reg_waddr_o), 32'd0);
    check({pfx, "_inst"},     inst_o, 32'd0);
    check({pfx, "_op1"},      op1_o, 32'd0);
    check({pfx, "_op2"},      op2_o, 32'd0);
    check({pfx, "_id_ready"}, 32'(id_ready_o), 32'd1);
  endtask

  vec_t    vecs[22];
  bundle_t model_q[$];

  initial begin
    int      tag;
    logic    f, v, r, do_pop, do_push;

    total_checks  = 0;
    passed_checks = 0;

    // flush, valid, tag, ex_ready -> exp ex_valid, exp id_ready, exp tag
    vecs[0]  = mkv(0, 1, 1,  1, 1, 1, 1);
    vecs[1]  = mkv(0, 1, 2,  1, 1, 1, 2);
    vecs[2]  = mkv(0, 1, 3,  1, 1, 1, 3);
    vecs[3]  = mkv(0, 1, 4,  1, 1, 1, 4);
    vecs[4]  = mkv(0, 0, 0,  1, 0, 1, 0);
    vecs[5]  = mkv(0, 1, 5,  0, 1, 1, 5);
    vecs[6]  = mkv(0, 1, 6,  0, 1, 0, 5);
    vecs[7]  = mkv(0, 1, 7,  0, 1, 0, 5);
    vecs[8]  = mkv(0, 0, 7,  1, 1, 1, 6);
    vecs[9]  = mkv(0, 0, 7,  1, 0, 1, 0);
    vecs[10] = mkv(0, 1, 7,  0, 1, 1, 7);
    vecs[11] = mkv(0, 0, 0,  1, 0, 1, 0);
    vecs[12] = mkv(0, 0, 0,  1, 0, 1, 0);
    vecs[13] = mkv(0, 1, 8,  0, 1, 1, 8);
    vecs[14] = mkv(0, 1, 9,  0, 1, 0, 8);
    vecs[15] = mkv(1, 1, 10, 0, 0, 1, 0);
    vecs[16] = mkv(0, 0, 0,  1, 0, 1, 0);
    vecs[17] = mkv(0, 0, 0,  1, 0, 1, 0);
    vecs[18] = mkv(0, 1, 11, 1, 1, 1, 11);
    vecs[19] = mkv(1, 1, 12, 1, 0, 1, 0);
    vecs[20] = mkv(0, 1, 13, 1, 1, 1, 13);
    vecs[21] = mkv(0, 0, 0,  1, 0, 1, 0);

    rst_n = 1'b0;
    driveBundle(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    checkResetOutputs("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      @(posedge clk);
      #2;
      checkOutput(vecs[i], i);
    end

    // Random valid/ready traffic against a FIFO scoreboard of accepted bundles.
    @(negedge clk);
    driveBundle(0, 0, 0, 0);
    tag = 100;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      check("rnd_ex_valid", 32'(ex_valid_o), 32'(model_q.size() > 0));
      check("rnd_id_ready", 32'(id_ready_o), 32'(model_q.size() < 2));
      if (model_q.size() > 0)
        checkPayload("rnd", model_q[0]);
      else
        check("rnd_we_bubble", 32'(reg_we_o), 32'd0);
      f = ($urandom_range(0, 49) == 0);
      v = ($urandom_range(0, 2) != 0);
      r = ($urandom_range(0, 2) != 0);
      driveBundle(f, v, tag, r);
      if (f) begin
        model_q.delete();
      end else begin
        do_push = v && (model_q.size() < 2);
        do_pop  = r && (model_q.size() > 0);
        if (do_pop) void'(model_q.pop_front());
        if (do_push) begin
          model_q.push_back(mkb(tag));
          tag++;
        end
      end
    end

    @(negedge clk);
    driveBundle(1, 0, 0, 0);
    @(negedge clk);
    driveBundle(0, 1, 50, 0);
    @(negedge clk);
    driveBundle(0, 1, 51, 0);
    @(negedge clk);
    driveBundle(0, 0, 0, 0);
    check("pre_reset_id_ready", 32'(id_ready_o), 32'd0);
    check("pre_reset_ex_valid", 32'(ex_valid_o), 32'd1);

    // Asynchronous reset asserted between edges must clear outputs without a clock.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    driveBundle(0, 0, 0, 1);
    repeat (2) @(negedge clk);
    check("post_reset_ex_valid", 32'(ex_valid_o), 32'd0);
    check("post_reset_id_ready", 32'(id_ready_o), 32'd1);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
